// File: rtl/rf_ctrl_fsm_if.sv
// Register-file / datapath control bundle between rf_ctrl_fsm (master) and the
// instruction register plus datapath (slave).
interface rf_ctrl_fsm_if;
  logic        s;
  logic [15:0] ir;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic        w;
  logic        ill;

  modport master (
    input  s, ir,
    output readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, w, ill
  );

  modport slave (
    output s, ir,
    input  readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, w, ill
  );
endinterface

// File: rtl/rf_ctrl_fsm.sv
// Multi-cycle controller sequencing MOV imm/reg, ADD, CMP, AND and MVN through
// the register file and datapath; Moore outputs from state plus latched fields.
module rf_ctrl_fsm #(
  parameter logic [1:0] VSEL_C   = 2'b00,
  parameter logic [1:0] VSEL_IMM = 2'b10
) (
  input  logic             clk,
  input  logic             reset_n,
  rf_ctrl_fsm_if.master    bus
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_DECODE,
    ST_WRITE_IMM,
    ST_GET_A,
    ST_GET_B,
    ST_ALU,
    ST_WRITE_REG,
    ST_ILLEGAL
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  rn_q, rn_d;
  logic [2:0]  rd_q, rd_d;
  logic [2:0]  rm_q, rm_d;

  logic is_cmp;
  logic zero_a;

  assign is_cmp = (opcode_q == 3'b101) && (op_q == 2'b01);
  // MOV reg and MVN pass B through the ALU, so A must be forced to zero.
  assign zero_a = (opcode_q == 3'b110) || ((opcode_q == 3'b101) && (op_q == 2'b11));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_WAIT;
      opcode_q <= '0;
      op_q     <= '0;
      rn_q     <= '0;
      rd_q     <= '0;
      rm_q     <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_q     <= op_d;
      rn_q     <= rn_d;
      rd_q     <= rd_d;
      rm_q     <= rm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op_d     = op_q;
    rn_d     = rn_q;
    rd_d     = rd_q;
    rm_d     = rm_q;
    case (state_q)
      ST_WAIT: begin
        if (bus.s) begin
          opcode_d = bus.ir[15:13];
          op_d     = bus.ir[12:11];
          rn_d     = bus.ir[10:8];
          rd_d     = bus.ir[7:5];
          rm_d     = bus.ir[2:0];
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case ({opcode_q, op_q})
          5'b110_10:                       state_d = ST_WRITE_IMM;
          5'b110_00:                       state_d = ST_GET_B;
          5'b101_00, 5'b101_01, 5'b101_10: state_d = ST_GET_A;
          5'b101_11:                       state_d = ST_GET_B;
          default:                         state_d = ST_ILLEGAL;
        endcase
      end
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_ALU;
      ST_ALU:       state_d = is_cmp ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_IMM: state_d = ST_WAIT;
      ST_WRITE_REG: state_d = ST_WAIT;
      ST_ILLEGAL:   state_d = ST_WAIT;
      default:      state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    bus.readnum  = '0;
    bus.writenum = '0;
    bus.write    = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.vsel     = VSEL_C;
    bus.w        = 1'b0;
    bus.ill      = 1'b0;
    case (state_q)
      ST_WAIT: bus.w = 1'b1;
      ST_WRITE_IMM: begin
        bus.writenum = rn_q;
        bus.vsel     = VSEL_IMM;
        bus.write    = 1'b1;
      end
      ST_GET_A: begin
        bus.readnum = rn_q;
        bus.loada   = 1'b1;
      end
      ST_GET_B: begin
        bus.readnum = rm_q;
        bus.loadb   = 1'b1;
      end
      ST_ALU: begin
        bus.asel  = zero_a;
        bus.loads = is_cmp;
        bus.loadc = !is_cmp;
      end
      ST_WRITE_REG: begin
        bus.writenum = rd_q;
        bus.vsel     = VSEL_C;
        bus.write    = 1'b1;
      end
      ST_ILLEGAL: bus.ill = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_ctrl_fsm.sv
// Self-checking bench for rf_ctrl_fsm: instruction table expanded into per-cycle
// expected outputs on a scoreboard queue, plus reset, ir-change and back-to-back sequences.
module tb_rf_ctrl_fsm;

  typedef logic [16:0] outvec_t;
  typedef enum int {K_IMM, K_ADD, K_CMP, K_MOVR, K_MVN, K_ILL} kind_e;

  typedef struct {
    logic [15:0] ir;
    kind_e       kind;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    string       name;
  } vec_t;

  logic clk;
  logic reset_n;
  rf_ctrl_fsm_if bus();

  rf_ctrl_fsm #(.VSEL_C(2'b00), .VSEL_IMM(2'b10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int write_pulses = 0;
  outvec_t exp_q[$];
  vec_t vecs[10];

  always @(posedge clk) if (bus.write === 1'b1) write_pulses++;

  // Strobe exclusivity watched on every active cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      n_checks++;
      if ($countones({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}) > 1) begin
        n_fail++;
        $display("FAIL strobe_exclusive at %0t: got %b, required at most one set",
                 $time, {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads});
      end
    end
  end

  function automatic outvec_t ov(input logic [2:0] rnum, input logic [2:0] wnum,
                                 input logic wr, input logic la, input logic lb,
                                 input logic lc, input logic ls, input logic as,
                                 input logic [1:0] vs, input logic w, input logic il);
    return {rnum, wnum, wr, la, lb, lc, ls, as, 1'b0, vs, w, il};
  endfunction

  function automatic outvec_t act();
    return {bus.readnum, bus.writenum, bus.write, bus.loada, bus.loadb, bus.loadc,
            bus.loads, bus.asel, bus.bsel, bus.vsel, bus.w, bus.ill};
  endfunction

  task automatic check(input string nm, input int cyc, input outvec_t a, input outvec_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: outputs got %h, required %h", nm, cyc, a, e);
    end
  endtask

  task automatic push_expect(input kind_e k, input logic [2:0] rn,
                             input logic [2:0] rd, input logic [2:0] rm);
    outvec_t dec, wt;
    dec = ov(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    wt  = ov(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    exp_q.push_back(dec);
    case (k)
      K_IMM: exp_q.push_back(ov(3'd0, rn, 1, 0, 0, 0, 0, 0, 2'b10, 0, 0));
      K_ADD: begin
        exp_q.push_back(ov(rn, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
        exp_q.push_back(ov(rm, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
        exp_q.push_back(ov(3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
        exp_q.push_back(ov(3'd0, rd, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
      end
      K_CMP: begin
        exp_q.push_back(ov(rn, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
        exp_q.push_back(ov(rm, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
        exp_q.push_back(ov(3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0));
      end
      K_MOVR, K_MVN: begin
        exp_q.push_back(ov(rm, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
        exp_q.push_back(ov(3'd0, 3'd0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0));
        exp_q.push_back(ov(3'd0, rd, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
      end
      default: exp_q.push_back(ov(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
    endcase
    exp_q.push_back(wt);
  endtask

  // Called at a negedge while the DUT sits in WAIT; returns at the negedge of
  // the cycle in which w rises again.
  task automatic run_instr(input vec_t v, input bit hold_s, input bit mangle);
    int cyc;
    outvec_t e;
    bus.ir = v.ir;
    bus.s  = 1'b1;
    @(posedge clk);
    push_expect(v.kind, v.rn, v.rd, v.rm);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      if (!hold_s) bus.s = 1'b0;
      if (mangle) begin
        bus.ir = 16'h0000;
        bus.s  = (cyc <= 3) ? 1'b1 : 1'b0;
      end
      e = exp_q.pop_front();
      check(v.name, cyc, act(), e);
    end
  endtask

  task automatic idle_check(input string nm);
    @(negedge clk);
    check(nm, 0, act(), ov(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int wp;
    vecs[0] = '{16'hD3FB, K_IMM,  3'd3, 3'd7, 3'd3, "mov_imm_r3_m5"};
    vecs[1] = '{16'hA140, K_ADD,  3'd1, 3'd2, 3'd0, "add_r2_r1_r0"};
    vecs[2] = '{16'hAD06, K_CMP,  3'd5, 3'd0, 3'd6, "cmp_r5_r6"};
    vecs[3] = '{16'hB783, K_ADD,  3'd7, 3'd4, 3'd3, "and_r4_r7_r3"};
    vecs[4] = '{16'hC0C2, K_MOVR, 3'd0, 3'd6, 3'd2, "mov_r6_r2"};
    vecs[5] = '{16'hB825, K_MVN,  3'd0, 3'd1, 3'd5, "mvn_r1_r5"};
    vecs[6] = '{16'hC800, K_ILL,  3'd0, 3'd0, 3'd0, "ill_110_01"};
    vecs[7] = '{16'hE000, K_ILL,  3'd0, 3'd0, 3'd0, "ill_111_00"};
    vecs[8] = '{16'hD77F, K_IMM,  3'd7, 3'd3, 3'd7, "mov_imm_r7_127"};
    vecs[9] = '{16'hA363, K_ADD,  3'd3, 3'd3, 3'd3, "add_r3_r3_r3"};

    reset_n = 1'b0;
    bus.s   = 1'b0;
    bus.ir  = 16'h0000;
    #1;
    check("reset_state", 0, act(), ov(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check("idle_after_reset");

    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i], 1'b0, 1'b0);
      idle_check({vecs[i].name, "_idle"});
    end

    // MVN with ir cleared and s pulsed after the accept edge.
    v = '{16'hB8E4, K_MVN, 3'd0, 3'd7, 3'd4, "mvn_r7_r4_irchg"};
    run_instr(v, 1'b0, 1'b1);
    idle_check("mvn_irchg_idle");

    // Illegal with s held, then MOV R0,#1 accepted on the single WAIT edge.
    v = '{16'h0000, K_ILL, 3'd0, 3'd0, 3'd0, "ill_0000_hold"};
    run_instr(v, 1'b1, 1'b0);
    v = '{16'hD001, K_IMM, 3'd0, 3'd0, 3'd1, "b2b_mov_r0_1"};
    run_instr(v, 1'b0, 1'b0);
    idle_check("b2b_idle");

    // Reset asserted in cycle 3 of an ADD aborts it with no write.
    bus.ir = 16'hA140;
    bus.s  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    wp = write_pulses;
    reset_n = 1'b0;
    #1;
    check("reset_mid_add", 3, act(), ov(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check("idle_after_abort");
    idle_check("idle_after_abort2");
    n_checks++;
    if (write_pulses != wp) begin
      n_fail++;
      $display("FAIL abort_no_write: write pulses got %0d, required 0", write_pulses - wp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
